// File: rtl/axis_pack_if.sv
// Handshake bundle for axis_pack: narrow receive stream and packed wide transmit stream.
// The slave view belongs to the packer, the master view to whatever drives and drains it.
interface axis_pack_if #(
    parameter int DIN_WIDTH = 32,
    parameter int RATIO     = 8
) ();
    localparam int DOUT_WIDTH = DIN_WIDTH * RATIO;
    localparam int CNT_WIDTH  = $clog2(RATIO + 1);

    logic [DIN_WIDTH-1:0]  axis_rx_tdata;
    logic                  axis_rx_tvalid;
    logic                  axis_rx_tlast;
    logic                  axis_rx_tready;
    logic [DOUT_WIDTH-1:0] axis_tx_tdata;
    logic [CNT_WIDTH-1:0]  axis_tx_twords;
    logic                  axis_tx_tlast;
    logic                  axis_tx_tvalid;
    logic                  axis_tx_tready;

    modport slave (
        input  axis_rx_tdata,
        input  axis_rx_tvalid,
        input  axis_rx_tlast,
        output axis_rx_tready,
        output axis_tx_tdata,
        output axis_tx_twords,
        output axis_tx_tlast,
        output axis_tx_tvalid,
        input  axis_tx_tready
    );

    modport master (
        output axis_rx_tdata,
        output axis_rx_tvalid,
        output axis_rx_tlast,
        input  axis_rx_tready,
        input  axis_tx_tdata,
        input  axis_tx_twords,
        input  axis_tx_tlast,
        input  axis_tx_tvalid,
        output axis_tx_tready
    );
endinterface

// File: rtl/axis_pack.sv
// Packs RATIO narrow stream words into one wide word; TLAST closes a partial,
// zero-padded group and the word count travels on a sideband.
module axis_pack #(
    parameter int DIN_WIDTH = 32,
    parameter int RATIO     = 8
) (
    input  logic         clk,
    input  logic         resetn,
    axis_pack_if.slave   bus
);
    localparam int DOUT_WIDTH = DIN_WIDTH * RATIO;
    localparam int CNT_WIDTH  = $clog2(RATIO + 1);
    localparam int IDX_WIDTH  = $clog2(RATIO);

    logic [DOUT_WIDTH-1:0] acc_r;
    logic [IDX_WIDTH-1:0]  idx_r;
    logic [DOUT_WIDTH-1:0] merged_s;
    logic                  accept_s;
    logic                  close_s;
    logic                  last_slot_s;

    // Input is ready whenever the output register is empty or being drained.
    assign bus.axis_rx_tready = resetn & (~bus.axis_tx_tvalid | bus.axis_tx_tready);

    // Merge the incoming word into its slot; slots above idx are still zero.
    always_comb begin
        accept_s    = bus.axis_rx_tvalid & bus.axis_rx_tready;
        last_slot_s = (idx_r == IDX_WIDTH'(RATIO - 1));
        close_s     = accept_s & (last_slot_s | bus.axis_rx_tlast);
        merged_s    = acc_r;
        merged_s[int'(idx_r) * DIN_WIDTH +: DIN_WIDTH] = bus.axis_rx_tdata;
    end

    // Accumulator, slot index and the registered output word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_r              <= {DOUT_WIDTH{1'b0}};
            idx_r              <= {IDX_WIDTH{1'b0}};
            bus.axis_tx_tdata  <= {DOUT_WIDTH{1'b0}};
            bus.axis_tx_twords <= {CNT_WIDTH{1'b0}};
            bus.axis_tx_tlast  <= 1'b0;
            bus.axis_tx_tvalid <= 1'b0;
        end else begin
            if (close_s) begin
                bus.axis_tx_tdata  <= merged_s;
                bus.axis_tx_twords <= CNT_WIDTH'(idx_r) + CNT_WIDTH'(1);
                bus.axis_tx_tlast  <= bus.axis_rx_tlast;
                bus.axis_tx_tvalid <= 1'b1;
                acc_r              <= {DOUT_WIDTH{1'b0}};
                idx_r              <= {IDX_WIDTH{1'b0}};
            end else if (accept_s) begin
                acc_r <= merged_s;
                idx_r <= idx_r + IDX_WIDTH'(1);
                // A consumed output with no replacement empties the register.
                if (bus.axis_tx_tready) begin
                    bus.axis_tx_tvalid <= 1'b0;
                end else begin
                    bus.axis_tx_tvalid <= bus.axis_tx_tvalid;
                end
            end else if (bus.axis_tx_tvalid & bus.axis_tx_tready) begin
                bus.axis_tx_tvalid <= 1'b0;
            end else begin
                bus.axis_tx_tvalid <= bus.axis_tx_tvalid;
            end
        end
    end
endmodule

// File: tb/tb_axis_pack.sv
// Scoreboard bench for axis_pack at DIN_WIDTH=32, RATIO=8.
module tb_axis_pack;
    localparam int DIN   = 32;
    localparam int RATIO = 8;
    localparam int DOUT  = DIN * RATIO;
    localparam int CNTW  = 4;

    typedef struct {
        logic [DOUT-1:0] data;
        logic [CNTW-1:0] words;
        logic            last;
    } exp_t;

    logic clk;
    logic resetn;
    axis_pack_if #(.DIN_WIDTH(DIN), .RATIO(RATIO)) bus ();

    axis_pack #(.DIN_WIDTH(DIN), .RATIO(RATIO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    exp_t sb[$];
    logic [DOUT-1:0] model_acc;
    int model_idx;

    // Reference model: groups accepted words, compares each taken output.
    always @(negedge clk) begin
        if (!resetn) begin
            sb.delete();
            model_acc = '0;
            model_idx = 0;
        end else begin
            if (bus.axis_tx_tvalid && bus.axis_tx_tready) begin
                n_checks++;
                n_out++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got output data=%h words=%0d, required no output", bus.axis_tx_tdata, bus.axis_tx_twords);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.axis_tx_tdata !== e.data || bus.axis_tx_twords !== e.words || bus.axis_tx_tlast !== e.last) begin
                        n_fail++;
                        $display("FAIL sb_output: got data=%h words=%0d last=%b, required data=%h words=%0d last=%b",
                                 bus.axis_tx_tdata, bus.axis_tx_twords, bus.axis_tx_tlast, e.data, e.words, e.last);
                    end
                end
            end
            if (bus.axis_rx_tvalid && bus.axis_rx_tready) begin
                model_acc[model_idx*DIN +: DIN] = bus.axis_rx_tdata;
                model_idx++;
                if (model_idx == RATIO || bus.axis_rx_tlast) begin
                    exp_t e;
                    e.data  = model_acc;
                    e.words = CNTW'(model_idx);
                    e.last  = bus.axis_rx_tlast;
                    sb.push_back(e);
                    model_acc = '0;
                    model_idx = 0;
                end
            end
        end
    end

    task automatic drive(input logic [DIN-1:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        bus.axis_rx_tvalid = 1'b1;
        bus.axis_rx_tdata  = d;
        bus.axis_rx_tlast  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.axis_rx_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive_timeout: got rx_tready=0 for 200 cycles, required 1");
        end
        @(posedge clk);
        #1;
        bus.axis_rx_tvalid = 1'b0;
        bus.axis_rx_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.axis_tx_tready = 1'b1;
        bus.axis_rx_tvalid = 1'b1;
        bus.axis_rx_tdata  = 32'h1234_5678;
        bus.axis_rx_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.axis_rx_tready !== 1'b0 || bus.axis_tx_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got rx_tready=%b tx_tvalid=%b, required 0 0", bus.axis_rx_tready, bus.axis_tx_tvalid);
        end
        n_checks++;
        if (bus.axis_tx_tdata !== {DOUT{1'b0}} || bus.axis_tx_twords !== 4'd0 || bus.axis_tx_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h words=%0d last=%b, required all 0", bus.axis_tx_tdata, bus.axis_tx_twords, bus.axis_tx_tlast);
        end
        bus.axis_rx_tvalid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.axis_rx_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", bus.axis_rx_tready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_group();
        logic [DOUT-1:0] exp;
        int base;
        bus.axis_tx_tready = 1'b1;
        exp = '0;
        for (int i = 1; i <= 8; i++) begin
            drive(DIN'(i), 1'b0);
            exp[(i-1)*DIN +: DIN] = DIN'(i);
        end
        n_checks++;
        if (bus.axis_tx_tvalid !== 1'b1 || bus.axis_tx_tdata !== exp || bus.axis_tx_twords !== 4'd8 || bus.axis_tx_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL full_group: got valid=%b data=%h words=%0d last=%b, required valid=1 data=%h words=8 last=0",
                     bus.axis_tx_tvalid, bus.axis_tx_tdata, bus.axis_tx_twords, bus.axis_tx_tlast, exp);
        end
        base = n_out;
        for (int i = 9; i <= 24; i++) drive(DIN'(i), 1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (n_out - base !== 3) begin
            n_fail++;
            $display("FAIL full_group_count: got %0d outputs, required 3", n_out - base);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_partial();
        logic [DOUT-1:0] exp;
        exp = '0;
        exp[95:0] = {32'hC, 32'hB, 32'hA};
        drive(32'hA, 1'b0);
        drive(32'hB, 1'b0);
        drive(32'hC, 1'b1);
        n_checks++;
        if (bus.axis_tx_tvalid !== 1'b1 || bus.axis_tx_tdata !== exp || bus.axis_tx_twords !== 4'd3 || bus.axis_tx_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL partial: got valid=%b data=%h words=%0d last=%b, required valid=1 data=%h words=3 last=1",
                     bus.axis_tx_tvalid, bus.axis_tx_tdata, bus.axis_tx_twords, bus.axis_tx_tlast, exp);
        end
        exp = '0;
        exp[31:0] = 32'h11;
        drive(32'h11, 1'b1);
        n_checks++;
        if (bus.axis_tx_tdata !== exp || bus.axis_tx_twords !== 4'd1) begin
            n_fail++;
            $display("FAIL partial_restart: got data=%h words=%0d, required data=%h words=1", bus.axis_tx_tdata, bus.axis_tx_twords, exp);
        end
    endtask

    task automatic test_single();
        logic [DOUT-1:0] exp;
        exp = '0;
        exp[31:0] = 32'hDEAD_BEEF;
        drive(32'hDEAD_BEEF, 1'b1);
        n_checks++;
        if (bus.axis_tx_tvalid !== 1'b1 || bus.axis_tx_tdata !== exp || bus.axis_tx_twords !== 4'd1 || bus.axis_tx_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL single_word: got valid=%b data=%h words=%0d last=%b, required valid=1 data=%h words=1 last=1",
                     bus.axis_tx_tvalid, bus.axis_tx_tdata, bus.axis_tx_twords, bus.axis_tx_tlast, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [DOUT-1:0] exp;
        int acc_cnt;
        int cyc;
        bit pend;
        bit fire;
        bus.axis_tx_tready = 1'b1;
        @(posedge clk);
        #1;
        bus.axis_tx_tready = 1'b0;
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            drive(32'h100 + DIN'(i), 1'b0);
            exp[i*DIN +: DIN] = 32'h100 + DIN'(i);
        end
        bus.axis_rx_tvalid = 1'b1;
        bus.axis_rx_tdata  = 32'h99;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.axis_rx_tready !== 1'b0 || bus.axis_tx_tvalid !== 1'b1 || bus.axis_tx_tdata !== exp || bus.axis_tx_twords !== 4'd8) begin
                n_fail++;
                $display("FAIL backpressure_hold cycle %0d: got rx_tready=%b valid=%b data=%h words=%0d, required 0 1 %h 8",
                         c, bus.axis_rx_tready, bus.axis_tx_tvalid, bus.axis_tx_tdata, bus.axis_tx_twords, exp);
            end
        end
        @(posedge clk);
        #1;
        bus.axis_tx_tready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.axis_rx_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: got rx_tready=%b, required 1", bus.axis_rx_tready);
        end
        @(posedge clk);
        #1;
        bus.axis_rx_tvalid = 1'b0;
        acc_cnt = 0;
        cyc = 0;
        pend = 1'b0;
        while (acc_cnt < 1000 && cyc < 30000) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                bus.axis_rx_tdata = $urandom;
                bus.axis_rx_tlast = ($urandom_range(0, 7) == 0);
            end
            bus.axis_rx_tvalid = pend;
            bus.axis_tx_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fire = bus.axis_rx_tvalid && bus.axis_rx_tready;
            @(posedge clk);
            #1;
            if (fire) begin
                pend = 1'b0;
                acc_cnt++;
            end
            cyc++;
        end
        n_checks++;
        if (acc_cnt != 1000) begin
            n_fail++;
            $display("FAIL random_progress: got %0d words accepted, required 1000", acc_cnt);
        end
        bus.axis_rx_tvalid = 1'b0;
        bus.axis_tx_tready = 1'b1;
        drive(32'h5A5A_5A5A, 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d outputs outstanding, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_group();
        logic [DOUT-1:0] exp;
        bus.axis_tx_tready = 1'b1;
        for (int i = 0; i < 5; i++) drive(32'hBAD0 + DIN'(i), 1'b0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            drive(32'h700 + DIN'(i), 1'b0);
            exp[i*DIN +: DIN] = 32'h700 + DIN'(i);
        end
        n_checks++;
        if (bus.axis_tx_tvalid !== 1'b1 || bus.axis_tx_tdata !== exp || bus.axis_tx_twords !== 4'd8 || bus.axis_tx_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_group: got valid=%b data=%h words=%0d last=%b, required valid=1 data=%h words=8 last=0",
                     bus.axis_tx_tvalid, bus.axis_tx_tdata, bus.axis_tx_twords, bus.axis_tx_tlast, exp);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: got %0d outputs outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        bus.axis_rx_tvalid = 1'b0;
        bus.axis_rx_tdata  = '0;
        bus.axis_rx_tlast  = 1'b0;
        bus.axis_tx_tready = 1'b0;
        model_acc = '0;
        model_idx = 0;
        test_reset();
        test_full_group();
        test_partial();
        test_single();
        test_backpressure();
        test_reset_mid_group();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
